// File: rtl/clarvi_alu_sequencer_pkg.sv
// Shared ALU op encoding and the instruction bundle handed to clarvi_ALU.
package clarvi_alu_sequencer_pkg;

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLT, OP_SLTU, OP_XOR, OP_OR, OP_AND,
      OP_SLL, OP_SRL, OP_SRA, OP_LUI, OP_JAL, OP_JALR
   } op_t;

   typedef struct packed {
      op_t         op;
      logic        instr_part;
      logic        is32_bit_op;
      logic [31:0] immediate;
      logic [63:0] pc;
      logic        immediate_used;
   } instr_t;

endpackage

// File: rtl/clarvi_alu_sequencer.sv
// Runs each 64-bit ALU op as two 32-bit passes: accept at N, passes at N+1/N+2, result valid from N+3.
// Result is held in DONE until out_ready; in_ready is high only in IDLE, flush aborts any op.
module clarvi_alu_sequencer
   import clarvi_alu_sequencer_pkg::*;
#(
   parameter int XLEN = 64,
   parameter int HALF = XLEN / 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  op_t             in_op,
   input  logic            in_is32,
   input  logic            in_imm_used,
   input  logic [XLEN-1:0] in_rs1,
   input  logic [XLEN-1:0] in_rs2,
   input  logic [XLEN-1:0] in_imm,
   input  logic [XLEN-1:0] in_pc,
   input  logic            flush,
   output instr_t          alu_instr,
   output logic [HALF-1:0] alu_rs1,
   output logic [HALF-1:0] alu_rs2,
   output logic            alu_stall,
   input  logic [HALF-1:0] alu_result,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result
);

   typedef enum logic [1:0] {IDLE, PASS_A, PASS_B, DONE} state_t;

   state_t          r_state;
   state_t          w_next_state;
   op_t             r_op;
   logic            r_is32;
   logic            r_imm_used;
   logic [XLEN-1:0] r_rs1;
   logic [XLEN-1:0] r_rs2;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_result;
   logic            w_hi_first;
   logic            w_part;
   logic            w_in_pass;

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_next_state = PASS_A;
         PASS_A:  w_next_state = PASS_B;
         PASS_B:  w_next_state = DONE;
         DONE:    if (out_ready) w_next_state = IDLE;
      endcase
      if (flush) w_next_state = IDLE;
   end

   // Comparisons and right shifts are decided from the top half down.
   assign w_hi_first = !r_is32 && (r_op inside {OP_SLT, OP_SLTU, OP_SRL, OP_SRA});
   assign w_part     = (r_state == PASS_B) ? !w_hi_first : w_hi_first;
   assign w_in_pass  = (r_state == PASS_A) || (r_state == PASS_B);

   assign in_ready   = (r_state == IDLE);
   assign out_valid  = (r_state == DONE);
   assign alu_stall  = !w_in_pass;
   assign out_result = r_result;
   assign alu_rs1    = w_part ? r_rs1[XLEN-1:HALF] : r_rs1[HALF-1:0];
   assign alu_rs2    = w_part ? r_rs2[XLEN-1:HALF] : r_rs2[HALF-1:0];

   always_comb begin
      alu_instr                = '0;
      alu_instr.op             = r_op;
      alu_instr.instr_part     = w_part;
      alu_instr.is32_bit_op    = r_is32;
      alu_instr.immediate      = w_part ? r_imm[XLEN-1:HALF] : r_imm[HALF-1:0];
      alu_instr.pc             = r_pc;
      alu_instr.immediate_used = r_imm_used;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_op       <= OP_ADD;
         r_is32     <= 1'b0;
         r_imm_used <= 1'b0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_result   <= '0;
      end else if (!flush) begin
         if (r_state == IDLE && in_valid) begin
            r_op       <= in_op;
            r_is32     <= in_is32;
            r_imm_used <= in_imm_used;
            r_rs1      <= in_rs1;
            r_rs2      <= in_rs2;
            r_imm      <= in_imm;
            r_pc       <= in_pc;
         end
         if (w_in_pass) begin
            if (w_part) r_result[XLEN-1:HALF] <= alu_result;
            else        r_result[HALF-1:0]    <= alu_result;
         end
      end
   end

endmodule
